// File: rtl/ap1000_interrupt_conditioner_if.sv
// ap1000_interrupt_conditioner_if: pin-side and controller-side interrupt signals of the conditioner
interface ap1000_interrupt_conditioner_if #(
  parameter int C_NUM_IRQ   = 11,
  parameter int C_OUT_WIDTH = 23
);
  logic [C_NUM_IRQ-1:0]   irq_in;
  logic [C_NUM_IRQ-1:0]   irq_enable;
  logic [C_NUM_IRQ-1:0]   irq_ack;
  logic [C_NUM_IRQ-1:0]   irq_status;
  logic [C_OUT_WIDTH-1:0] irq_out;
  modport master (output irq_in, irq_enable, irq_ack, input irq_status, irq_out);
  modport slave  (input irq_in, irq_enable, irq_ack, output irq_status, irq_out);
endinterface

// File: rtl/ap1000_interrupt_conditioner.sv
// ap1000_interrupt_conditioner: per-channel sync, polarity fix, glitch filter, level/edge latch and mask
module ap1000_interrupt_conditioner #(
  parameter int                   C_NUM_IRQ        = 11,
  parameter int                   C_OUT_WIDTH      = 23,
  parameter int                   C_SYNC_STAGES    = 2,
  parameter int                   C_FILTER_CYCLES  = 4,
  parameter logic [C_NUM_IRQ-1:0] C_IN_ACTIVE_LOW  = 11'h7FE,
  parameter logic [C_NUM_IRQ-1:0] C_EDGE_MASK      = 11'h000,
  parameter bit                   C_OUT_ACTIVE_LOW = 1'b1
) (
  input logic                          sys_clk,
  input logic                          sys_rst_n,
  ap1000_interrupt_conditioner_if.slave bus
);
  localparam int CW = $clog2(C_FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(C_FILTER_CYCLES - 1);
  if (C_OUT_WIDTH < C_NUM_IRQ || C_FILTER_CYCLES == 0) begin : g_bad
    $error("ap1000_interrupt_conditioner: C_OUT_WIDTH < C_NUM_IRQ or C_FILTER_CYCLES == 0");
  end
  logic [C_NUM_IRQ-1:0]   filt_v;
  logic [C_NUM_IRQ-1:0]   pend_v;
  logic [C_OUT_WIDTH-1:0] out_d;
  logic [C_OUT_WIDTH-1:0] out_q;
  for (genvar i = 0; i < C_NUM_IRQ; i++) begin : g_ch
    logic [C_SYNC_STAGES-1:0] sync;
    logic [CW-1:0]            cnt;
    logic                     filt;
    logic                     filt_d;
    logic                     pend;
    logic                     act;
    assign act = sync[C_SYNC_STAGES-1] ^ C_IN_ACTIVE_LOW[i];
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync   <= {C_SYNC_STAGES{C_IN_ACTIVE_LOW[i]}};
        cnt    <= '0;
        filt   <= 1'b0;
        filt_d <= 1'b0;
        pend   <= 1'b0;
      end else begin
        sync   <= {sync[C_SYNC_STAGES-2:0], bus.irq_in[i]};
        cnt    <= (act == filt || cnt == LAST) ? '0 : cnt + CW'(1);
        filt   <= (act != filt && cnt == LAST) ? act : filt;
        filt_d <= filt;
        // edge mode: a new rise beats a same-cycle ack so no event is lost
        pend   <= C_EDGE_MASK[i] ? ((filt & ~filt_d) | (pend & ~bus.irq_ack[i])) : filt;
      end
    end
    assign filt_v[i] = filt;
    assign pend_v[i] = pend;
  end
  always_comb begin
    out_d = {C_OUT_WIDTH{C_OUT_ACTIVE_LOW}};
    out_d[C_NUM_IRQ-1:0] = (pend_v & bus.irq_enable) ^ {C_NUM_IRQ{C_OUT_ACTIVE_LOW}};
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) out_q <= {C_OUT_WIDTH{C_OUT_ACTIVE_LOW}};
    else            out_q <= out_d;
  end
  assign bus.irq_out    = out_q;
  assign bus.irq_status = filt_v;
endmodule

// File: tb/tb_ap1000_interrupt_conditioner.sv
// tb_ap1000_interrupt_conditioner: directed vectors checked against a cycle model and literal expectations
module tb_ap1000_interrupt_conditioner;
  localparam int N = 11;
  localparam int W = 23;
  localparam int S = 2;
  localparam int F = 4;
  localparam logic [N-1:0] AL = 11'h7FE;
  localparam logic [N-1:0] EM = 11'h001;
  localparam bit OAL = 1'b1;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  ap1000_interrupt_conditioner_if #(.C_NUM_IRQ(N), .C_OUT_WIDTH(W)) bus ();
  ap1000_interrupt_conditioner #(
    .C_NUM_IRQ(N), .C_OUT_WIDTH(W), .C_SYNC_STAGES(S), .C_FILTER_CYCLES(F),
    .C_IN_ACTIVE_LOW(AL), .C_EDGE_MASK(EM), .C_OUT_ACTIVE_LOW(OAL)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus.slave)
  );
  always #5 sys_clk = ~sys_clk;
  logic [N-1:0] dly [S];
  logic [N-1:0] m_filt, m_prev, m_pend;
  logic [W-1:0] m_out;
  int run [N];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset;
    for (int s = 0; s < S; s++) dly[s] = AL;
    m_filt = '0;
    m_prev = '0;
    m_pend = '0;
    m_out = {W{OAL}};
    for (int c = 0; c < N; c++) run[c] = 0;
  endtask
  task automatic model_step;
    logic [N-1:0] act;
    m_out = {W{OAL}};
    m_out[N-1:0] = (m_pend & bus.irq_enable) ^ {N{OAL}};
    m_pend = (EM & ((m_filt & ~m_prev) | (m_pend & ~bus.irq_ack))) | (~EM & m_filt);
    m_prev = m_filt;
    act = dly[S-1] ^ AL;
    for (int c = 0; c < N; c++) begin
      if (act[c] != m_filt[c]) begin
        run[c]++;
        if (run[c] == F) begin
          m_filt[c] = act[c];
          run[c] = 0;
        end
      end else run[c] = 0;
    end
    for (int s = S - 1; s > 0; s--) dly[s] = dly[s-1];
    dly[0] = bus.irq_in;
  endtask
  task automatic tick;
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step();
    #1;
  endtask
  task automatic lat(input int ch, input logic val, output int n);
    n = 0;
    while (bus.irq_out[ch] !== val && n < 20) begin
      tick();
      n++;
    end
  endtask
  initial begin
    forever begin
      @(negedge sys_clk);
      check("model_irq_out", 32'(bus.irq_out), 32'(m_out));
      check("model_irq_status", 32'(bus.irq_status), 32'(m_filt));
    end
  end
  initial begin
    int n;
    logic seen;
    model_reset();
    bus.irq_in = AL;
    bus.irq_enable = '1;
    bus.irq_ack = '0;
    for (int k = 0; k < 6; k++) begin
      bus.irq_in = bus.irq_in ^ '1;
      tick();
      check("reset_out", 32'(bus.irq_out), 32'h7FFFFF);
      check("reset_status", 32'(bus.irq_status), 32'h0);
    end
    bus.irq_in = AL;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (4) tick();
    bus.irq_in[1] = 1'b0;
    lat(1, 1'b0, n);
    check("level_assert_latency", n, 8);
    repeat (3) tick();
    bus.irq_in[1] = 1'b1;
    lat(1, 1'b1, n);
    check("level_release_latency", n, 8);
    bus.irq_in[2] = 1'b0;
    repeat (3) tick();
    bus.irq_in[2] = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | bus.irq_status[2] | ~bus.irq_out[2];
    end
    check("glitch_3_ignored", 32'(seen), 32'h0);
    bus.irq_in[2] = 1'b0;
    repeat (4) tick();
    bus.irq_in[2] = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      tick();
      seen = seen | ~bus.irq_out[2];
    end
    check("glitch_4_passes", 32'(seen), 32'h1);
    bus.irq_in[0] = 1'b1;
    repeat (6) tick();
    bus.irq_in[0] = 1'b0;
    repeat (12) tick();
    check("edge_latched", 32'(bus.irq_out[0]), 32'h0);
    check("edge_status_low", 32'(bus.irq_status[0]), 32'h0);
    bus.irq_ack[0] = 1'b1;
    tick();
    bus.irq_ack[0] = 1'b0;
    tick();
    check("edge_ack_clears", 32'(bus.irq_out[0]), 32'h1);
    bus.irq_in[0] = 1'b1;
    repeat (6) tick();
    bus.irq_in[0] = 1'b0;
    repeat (12) tick();
    check("edge_relatched", 32'(bus.irq_out[0]), 32'h0);
    bus.irq_in[0] = 1'b1;
    repeat (6) tick();
    bus.irq_ack[0] = 1'b1;
    tick();
    bus.irq_ack[0] = 1'b0;
    bus.irq_in[0] = 1'b0;
    repeat (12) tick();
    check("edge_set_beats_ack", 32'(bus.irq_out[0]), 32'h0);
    bus.irq_enable[3] = 1'b0;
    bus.irq_in[3] = 1'b0;
    repeat (12) tick();
    check("mask_out", 32'(bus.irq_out[3]), 32'h1);
    check("mask_status", 32'(bus.irq_status[3]), 32'h1);
    bus.irq_enable[3] = 1'b1;
    tick();
    check("unmask_out", 32'(bus.irq_out[3]), 32'h0);
    bus.irq_in[3] = 1'b1;
    bus.irq_in[5] = 1'b0;
    repeat (12) tick();
    check("pre_reset_ch0", 32'(bus.irq_out[0]), 32'h0);
    check("pre_reset_ch5", 32'(bus.irq_out[5]), 32'h0);
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_out", 32'(bus.irq_out), 32'h7FFFFF);
    check("async_reset_status", 32'(bus.irq_status), 32'h0);
    bus.irq_in = AL;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (15) tick();
    check("post_reset_idle", 32'(bus.irq_out), 32'h7FFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
